fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the core. It masters the instruction Wishbone bus, tracks the PC, and produces the instr/PC/PC+4/trap stream that the IF-ID pipeline register consumes. It also absorbs redirects from later stages and the ID-side stall, and raises fetch traps (misaligned target, bus error).

Parameters:
RESET_ADDR, 32'h8000_0000, PC loaded at reset.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset, synchronous, active-low.
iwbm_addr_o  out  32  bus address, word aligned.
iwbm_cyc_o  out  1  bus cycle active.
iwbm_stb_o  out  1  bus strobe.
iwbm_dat_i  in  32  read data.
iwbm_ack_i  in  1  read complete.
iwbm_err_i  in  1  bus error, terminates the cycle.
stall_i  in  1  downstream cannot accept (IF-ID en = !stall_i).
pc_sel_i  in  1  redirect request (branch/jump/trap/xret).
pc_target_i  in  32  redirect target.
instr_if  out  32  fetched instruction.
PC_if  out  32  address of instr_if.
PC4_if  out  32  PC_if + 4.
trap_code_if  out  4  fetch trap cause.
is_trap_if  out  1  instr_if carries a trap.
valid_if  out  1  output slot holds a live entry; top drives IF-ID clear = !valid_if.

Behaviour:
- Reset (rst_i==0 at edge): pc=RESET_ADDR, state IDLE. cyc/stb=0, addr=0, all *_if outputs=0, valid_if=0, skid empty. Reset mid-bus-cycle drops cyc/stb at that edge. Late acks are ignored.
- Consume event: valid_if & !stall_i at a clock edge. The slot is free when !valid_if or a consume event occurs.
- IDLE: move to REQ on the next edge.
- REQ: if pc[1:0]!=0, no strobe. When the slot is free, load the trap entry (instr=NOP 32'h0000_0013, PC_if=pc, is_trap=1, code=TRAP_MISALIGN 4'd0), then go to HALT. Otherwise drive cyc=stb=1, addr=pc.
  - On ack with slot free: load instr=dat_i, PC_if=pc, PC4_if=pc+4, is_trap=0, valid=1. Then pc+=4 and stay in REQ, so the next address is driven on the next cycle. Sustained throughput is 1 instruction/cycle with zero-wait acks.
  - On ack with slot blocked: capture into the 1-entry skid, drop cyc/stb, pc+=4, go to HOLD.
  - On err: same slot/skid rules, but the entry is a trap: instr=NOP, code=TRAP_ACCESS 4'd1. Go to HALT, or HOLD-then-HALT if the entry went to the skid.
- HOLD: no bus activity. On a consume event, move skid to output and go to REQ (or HALT if the skid held a trap).
- HALT: no fetching. Outputs are consumed normally. Leave only on redirect.
- DISCARD: keep cyc=stb asserted with the old address until ack or err. Drop the response and go to REQ.
- Redirect (pc_sel_i=1): highest priority after reset, any state.
  - At that edge: pc=pc_target_i, valid_if=0, skid emptied. The flush is applied even if stall_i=1.
  - If a cycle is in flight without ack/err this cycle, go to DISCARD; otherwise go to REQ.
  - A redirect that coincides with ack/err discards that response.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0. An ack never arrives without stb; a simultaneous ack and err is treated as err.
- Output fields are registered, with no combinational input-to-output paths except iwbm_stb_o/cyc_o (state-derived only).

Decomposition:
- core_pkg: TRAP_MISALIGN, TRAP_ACCESS, NOP_INSTR, fetch state enum (IDLE, REQ, HOLD, DISCARD, HALT).
- Skid register and state machine stay inline; no sub-module.

Test Plan:
1. Release reset, ack 1 cycle after stb with dat 0x00500093 → addr 0x8000_0000; instr_if=0x00500093, PC_if=0x8000_0000, PC4_if=0x8000_0004, valid_if=1; next addr 0x8000_0004.
2. Zero-wait acks, stall_i=0, 4 words → 4 consecutive valid outputs at PCs 0x8000_0000..0x8000_000C, one per cycle.
3. stall_i=1 for 3 cycles while an ack arrives → output unchanged, ack word held in skid, stb low. Release → in-order delivery, fetch resumes at the next PC.
4. Redirect to 0x8000_0100 while a stb is outstanding, ack 2 cycles later with 0xDEADBEEF → that word never appears, valid_if=0, next addr 0x8000_0100.
5. Redirect to 0x8000_0102 → no stb; is_trap_if=1, trap_code_if=0, instr_if=0x0000_0013, PC_if=0x8000_0102; stays halted until a redirect to 0x8000_0200 restarts fetch there.
6. iwbm_err_i on fetch of 0x8000_0008 → trap_code_if=1, PC_if=0x8000_0008, fetch halts. Separately, rst_i=0 mid-REQ → cyc/stb and valid_if are 0 after that edge, and fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the instruction-fetch stage.
//   TRAP_MISALIGN / TRAP_ACCESS : fetch trap cause codes
//   NOP_INSTR                   : instruction word placed in trap entries
//   fetch_state_t               : fetch state machine encoding
//   fetch_entry_t               : one fetched entry (output slot / skid)
//   word_align()                : clears the byte-offset bits of an address
package core_pkg;

  localparam logic [3:0]  TRAP_MISALIGN = 4'd0;
  localparam logic [3:0]  TRAP_ACCESS   = 4'd1;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    DISCARD,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_trap;
    logic [3:0]  code;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Masters the instruction Wishbone bus,
// tracks the PC and feeds the IF-ID register with instr/PC/PC+4/trap entries.
// Ports:
//   clk_i, rst_i          : clock (rising edge), synchronous active-low reset
//   iwbm_addr_o/cyc_o/stb_o : bus request (address is word aligned)
//   iwbm_dat_i/ack_i/err_i  : bus response
//   stall_i               : downstream cannot accept the output slot
//   pc_sel_i, pc_target_i : redirect request and target
//   instr_if, PC_if, PC4_if, trap_code_if, is_trap_if, valid_if : output slot
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        stall_i,
  input  logic        pc_sel_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] instr_if,
  output logic [31:0] PC_if,
  output logic [31:0] PC4_if,
  output logic [3:0]  trap_code_if,
  output logic        is_trap_if,
  output logic        valid_if
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  fetch_entry_t skid_q;
  logic         skid_valid_q;

  logic [31:0]  instr_q;
  logic [31:0]  pc_out_q;
  logic [31:0]  pc4_out_q;
  logic [3:0]   code_q;
  logic         trap_q;
  logic         valid_q;

  logic         pc_misaligned;
  logic         in_flight;
  logic         bus_done;
  logic         consume;
  logic         slot_free;
  fetch_entry_t bus_entry;
  fetch_entry_t misalign_entry;

  // A strobe is only raised for aligned PCs in REQ, or while waiting out an
  // abandoned cycle in DISCARD; the bus handshake depends on state alone.
  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign in_flight     = ((state_q == REQ) && !pc_misaligned) || (state_q == DISCARD);
  assign bus_done      = iwbm_ack_i || iwbm_err_i;
  assign consume       = valid_q && !stall_i;
  assign slot_free     = !valid_q || consume;

  assign iwbm_cyc_o  = in_flight;
  assign iwbm_stb_o  = in_flight;
  assign iwbm_addr_o = addr_q;

  // Error wins over a simultaneous ack and turns the response into a trap.
  always_comb begin
    bus_entry.pc = pc_q;
    if (iwbm_err_i) begin
      bus_entry.instr   = NOP_INSTR;
      bus_entry.is_trap = 1'b1;
      bus_entry.code    = TRAP_ACCESS;
    end else begin
      bus_entry.instr   = iwbm_dat_i;
      bus_entry.is_trap = 1'b0;
      bus_entry.code    = 4'd0;
    end
  end

  always_comb begin
    misalign_entry.instr   = NOP_INSTR;
    misalign_entry.pc      = pc_q;
    misalign_entry.is_trap = 1'b1;
    misalign_entry.code    = TRAP_MISALIGN;
  end

  // Fetch state machine, output slot and skid. Reset first, then redirect
  // (which flushes regardless of stall), then normal per-state behaviour.
  // A consume event empties the slot unless a new entry is loaded that edge.
  // The bus address follows the PC except in DISCARD, where the abandoned
  // cycle must keep its original address until it terminates.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      addr_q       <= 32'd0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      instr_q      <= 32'd0;
      pc_out_q     <= 32'd0;
      pc4_out_q    <= 32'd0;
      code_q       <= 4'd0;
      trap_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else if (pc_sel_i) begin
      pc_q         <= pc_target_i;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      if (in_flight && !bus_done) begin
        state_q <= DISCARD;
      end else begin
        state_q <= REQ;
        addr_q  <= word_align(pc_target_i);
      end
    end else begin
      if (consume) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          addr_q  <= word_align(pc_q);
        end
        REQ: begin
          if (pc_misaligned) begin
            if (slot_free) begin
              instr_q   <= misalign_entry.instr;
              pc_out_q  <= misalign_entry.pc;
              pc4_out_q <= misalign_entry.pc + 32'd4;
              trap_q    <= misalign_entry.is_trap;
              code_q    <= misalign_entry.code;
              valid_q   <= 1'b1;
              state_q   <= HALT;
            end
          end else if (bus_done) begin
            if (slot_free) begin
              instr_q   <= bus_entry.instr;
              pc_out_q  <= bus_entry.pc;
              pc4_out_q <= bus_entry.pc + 32'd4;
              trap_q    <= bus_entry.is_trap;
              code_q    <= bus_entry.code;
              valid_q   <= 1'b1;
            end else begin
              skid_q       <= bus_entry;
              skid_valid_q <= 1'b1;
            end
            if (iwbm_err_i) begin
              state_q <= slot_free ? HALT : HOLD;
            end else begin
              pc_q    <= pc_q + 32'd4;
              addr_q  <= word_align(pc_q + 32'd4);
              state_q <= slot_free ? REQ : HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            instr_q      <= skid_q.instr;
            pc_out_q     <= skid_q.pc;
            pc4_out_q    <= skid_q.pc + 32'd4;
            trap_q       <= skid_q.is_trap;
            code_q       <= skid_q.code;
            valid_q      <= skid_valid_q;
            skid_valid_q <= 1'b0;
            state_q      <= skid_q.is_trap ? HALT : REQ;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        DISCARD: begin
          if (bus_done) begin
            state_q <= REQ;
            addr_q  <= word_align(pc_q);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instr_if     = instr_q;
  assign PC_if        = pc_out_q;
  assign PC4_if       = pc4_out_q;
  assign trap_code_if = code_q;
  assign is_trap_if   = trap_q;
  assign valid_if     = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, self-checking bench for fetch_unit. Each step
// drives the inputs, advances one clock edge and compares the registered
// outputs against hand-computed values one time unit after the edge.
module tb_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o;
  logic        iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i;
  logic        iwbm_err_i;
  logic        stall_i;
  logic        pc_sel_i;
  logic [31:0] pc_target_i;
  logic [31:0] instr_if;
  logic [31:0] PC_if;
  logic [31:0] PC4_if;
  logic [3:0]  trap_code_if;
  logic        is_trap_if;
  logic        valid_if;

  int assert_count = 0;
  int fail_count   = 0;

  fetch_unit #(.RESET_ADDR(32'h8000_0000)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .iwbm_addr_o  (iwbm_addr_o),
    .iwbm_cyc_o   (iwbm_cyc_o),
    .iwbm_stb_o   (iwbm_stb_o),
    .iwbm_dat_i   (iwbm_dat_i),
    .iwbm_ack_i   (iwbm_ack_i),
    .iwbm_err_i   (iwbm_err_i),
    .stall_i      (stall_i),
    .pc_sel_i     (pc_sel_i),
    .pc_target_i  (pc_target_i),
    .instr_if     (instr_if),
    .PC_if        (PC_if),
    .PC4_if       (PC4_if),
    .trap_code_if (trap_code_if),
    .is_trap_if   (is_trap_if),
    .valid_if     (valid_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle's inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic rst, input logic ack, input logic err,
                               input logic [31:0] dat, input logic stall,
                               input logic sel, input logic [31:0] target);
    rst_i       = rst;
    iwbm_ack_i  = ack;
    iwbm_err_i  = err;
    iwbm_dat_i  = dat;
    stall_i     = stall;
    pc_sel_i    = sel;
    pc_target_i = target;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("rst_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    checkOutput("rst_cyc",   {31'd0, iwbm_cyc_o}, 32'd0);
    checkOutput("rst_addr",  iwbm_addr_o, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_if}, 32'd0);
    checkOutput("rst_instr", instr_if, 32'd0);
    checkOutput("rst_pc",    PC_if, 32'd0);
    checkOutput("rst_trap",  {31'd0, is_trap_if}, 32'd0);

    // Test 1: first fetch, ack one cycle after the strobe
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t1_stb",  {31'd0, iwbm_stb_o}, 32'd1);
    checkOutput("t1_addr", iwbm_addr_o, 32'h8000_0000);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t1_wait_valid", {31'd0, valid_if}, 32'd0);
    applyStimulus(1, 1, 0, 32'h0050_0093, 0, 0, 32'h0);
    checkOutput("t1_instr", instr_if, 32'h0050_0093);
    checkOutput("t1_pc",    PC_if, 32'h8000_0000);
    checkOutput("t1_pc4",   PC4_if, 32'h8000_0004);
    checkOutput("t1_valid", {31'd0, valid_if}, 32'd1);
    checkOutput("t1_next",  iwbm_addr_o, 32'h8000_0004);

    // Test 2: restart, then four zero-wait acks
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t2_addr0", iwbm_addr_o, 32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 32'h1000_0000 + i, 0, 0, 32'h0);
      checkOutput("t2_instr", instr_if, 32'h1000_0000 + i);
      checkOutput("t2_pc",    PC_if, 32'h8000_0000 + 4 * i);
      checkOutput("t2_valid", {31'd0, valid_if}, 32'd1);
    end
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t2_drain", {31'd0, valid_if}, 32'd0);
    checkOutput("t2_addr",  iwbm_addr_o, 32'h8000_0010);

    // Test 3: stall while a second ack arrives -> skid, then in-order release
    applyStimulus(1, 1, 0, 32'hA000_0000, 0, 0, 32'h0);
    checkOutput("t3_a0", instr_if, 32'hA000_0000);
    applyStimulus(1, 1, 0, 32'hA000_0001, 1, 0, 32'h0);
    checkOutput("t3_hold_instr", instr_if, 32'hA000_0000);
    checkOutput("t3_hold_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t3_stall_instr", instr_if, 32'hA000_0000);
    checkOutput("t3_stall_pc",    PC_if, 32'h8000_0010);
    checkOutput("t3_stall_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t3_a1",       instr_if, 32'hA000_0001);
    checkOutput("t3_a1_pc",    PC_if, 32'h8000_0014);
    checkOutput("t3_a1_valid", {31'd0, valid_if}, 32'd1);
    checkOutput("t3_resume",   iwbm_addr_o, 32'h8000_0018);
    checkOutput("t3_stb",      {31'd0, iwbm_stb_o}, 32'd1);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t3_empty", {31'd0, valid_if}, 32'd0);

    // Test 4: redirect with a strobe outstanding; late ack is discarded
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h8000_0100);
    checkOutput("t4_valid", {31'd0, valid_if}, 32'd0);
    checkOutput("t4_stb",   {31'd0, iwbm_stb_o}, 32'd1);
    checkOutput("t4_old",   iwbm_addr_o, 32'h8000_0018);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0);
    checkOutput("t4_drop_valid", {31'd0, valid_if}, 32'd0);
    checkOutput("t4_drop_instr", instr_if, 32'hA000_0001);
    checkOutput("t4_new_addr",   iwbm_addr_o, 32'h8000_0100);

    // Test 5: misaligned redirect (coinciding with an ack) -> trap, halt
    applyStimulus(1, 1, 0, 32'h1111_1111, 0, 1, 32'h8000_0102);
    checkOutput("t5_nostb", {31'd0, iwbm_stb_o}, 32'd0);
    checkOutput("t5_flush", {31'd0, valid_if}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_trap",  {31'd0, is_trap_if}, 32'd1);
    checkOutput("t5_code",  {28'd0, trap_code_if}, 32'd0);
    checkOutput("t5_instr", instr_if, 32'h0000_0013);
    checkOutput("t5_pc",    PC_if, 32'h8000_0102);
    checkOutput("t5_valid", {31'd0, valid_if}, 32'd1);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t5_halt_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    checkOutput("t5_halt_valid", {31'd0, valid_if}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h8000_0200);
    checkOutput("t5_restart_stb",  {31'd0, iwbm_stb_o}, 32'd1);
    checkOutput("t5_restart_addr", iwbm_addr_o, 32'h8000_0200);

    // Test 6a: bus error on fetch of 0x8000_0008
    applyStimulus(1, 1, 0, 32'h2222_2222, 0, 1, 32'h8000_0008);
    checkOutput("t6_addr", iwbm_addr_o, 32'h8000_0008);
    applyStimulus(1, 0, 1, 32'h0, 0, 0, 32'h0);
    checkOutput("t6_code",  {28'd0, trap_code_if}, 32'd1);
    checkOutput("t6_trap",  {31'd0, is_trap_if}, 32'd1);
    checkOutput("t6_pc",    PC_if, 32'h8000_0008);
    checkOutput("t6_instr", instr_if, 32'h0000_0013);
    checkOutput("t6_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t6_halt_stb", {31'd0, iwbm_stb_o}, 32'd0);

    // Test 6b: reset while in REQ with a live output entry
    applyStimulus(1, 0, 0, 32'h0, 0, 1, 32'h8000_0300);
    applyStimulus(1, 1, 0, 32'hB000_0000, 0, 0, 32'h0);
    checkOutput("t6_live", {31'd0, valid_if}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t6_rst_stb",   {31'd0, iwbm_stb_o}, 32'd0);
    checkOutput("t6_rst_cyc",   {31'd0, iwbm_cyc_o}, 32'd0);
    checkOutput("t6_rst_valid", {31'd0, valid_if}, 32'd0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("t6_restart", iwbm_addr_o, 32'h8000_0000);

    // PC wrap-around at the top of the address space
    applyStimulus(1, 1, 0, 32'h3333_3333, 0, 1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr", iwbm_addr_o, 32'hFFFF_FFFC);
    applyStimulus(1, 1, 0, 32'hC000_0000, 0, 0, 32'h0);
    checkOutput("wrap_instr", instr_if, 32'hC000_0000);
    checkOutput("wrap_pc",    PC_if, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4",   PC4_if, 32'h0000_0000);
    checkOutput("wrap_next",  iwbm_addr_o, 32'h0000_0000);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
